// File: rtl/seg7_pkg.sv
// seg7_pkg: shared hex-to-segment table, unlit pattern and scan state type.
package seg7_pkg;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef enum logic [1:0] {IDLE, ON, DEAD} scan_state_t;
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to [GFEDCBA] lookup, 1 = lit.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);
  assign segments = SEG_TABLE[nibble];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment scan with dwell, dead time,
// leading-zero blanking and selectable pin polarity; all pins come from flops.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 1000,
  parameter int DEAD_CLKS      = 2,
  parameter bit ACTIVE_LOW_SEG = 1'b0,
  parameter bit ACTIVE_LOW_DIG = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_blank_lz,
  output logic [6:0]              o_segments,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_digit_en
);
  localparam int CNT_MAX = CLKS_PER_DIGIT > DEAD_CLKS ? CLKS_PER_DIGIT : DEAD_CLKS;
  localparam int CNT_W = $clog2(CNT_MAX > 2 ? CNT_MAX : 2);
  localparam int IDX_W = $clog2(NUM_DIGITS > 2 ? NUM_DIGITS : 2);
  localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CLKS > 0 ? DEAD_CLKS - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW_SEG}};
  localparam logic [NUM_DIGITS-1:0] DIG_POL = {NUM_DIGITS{ACTIVE_LOW_DIG}};
  scan_state_t state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx, idx_inc;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0] shadow_dp, blank, den_nx;
  logic [3:0] nibs [NUM_DIGITS];
  logic [6:0] dec_seg, seg_nx;
  logic dp_nx, lit_nx;
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    assign nibs[k] = shadow_value[4*k +: 4];
    if (k == 0) begin : g_lsd
      assign blank[k] = 1'b0;
    end else begin : g_upper
      // Blank when this nibble and every nibble above it are zero.
      assign blank[k] = i_blank_lz && shadow_value[4*NUM_DIGITS-1:4*k] == '0;
    end
  end
  assign idx_inc = idx == IDX_LAST ? '0 : idx + 1'b1;
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    cnt_nx = cnt + 1'b1;
    if (!i_enable) begin
      state_nx = IDLE;
      idx_nx = '0;
      cnt_nx = '0;
    end else if (state == IDLE) begin
      state_nx = ON;
      idx_nx = '0;
      cnt_nx = '0;
    end else if (state == ON && cnt == ON_LAST) begin
      state_nx = DEAD_CLKS > 0 ? DEAD : ON;
      idx_nx = DEAD_CLKS > 0 ? idx : idx_inc;
      cnt_nx = '0;
    end else if (state == DEAD && cnt == DEAD_LAST) begin
      state_nx = ON;
      idx_nx = idx_inc;
      cnt_nx = '0;
    end
  end
  // Output flops are fed from the upcoming phase so pins change on the entry edge.
  seg7_hex_decode u_dec (.nibble(nibs[idx_nx]), .segments(dec_seg));
  assign lit_nx = state_nx == ON;
  assign seg_nx = lit_nx && !blank[idx_nx] ? dec_seg : SEG_OFF;
  assign dp_nx = lit_nx && shadow_dp[idx_nx];
  assign den_nx = lit_nx ? NUM_DIGITS'(1) << idx_nx : '0;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      shadow_value <= '0;
      shadow_dp <= '0;
      o_segments <= SEG_OFF ^ SEG_POL;
      o_dp <= ACTIVE_LOW_SEG;
      o_digit_en <= DIG_POL;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      cnt <= cnt_nx;
      if (i_load) begin
        shadow_value <= i_value;
        shadow_dp <= i_dp;
      end
      o_segments <= seg_nx ^ SEG_POL;
      o_dp <= dp_nx ^ ACTIVE_LOW_SEG;
      o_digit_en <= den_nx ^ DIG_POL;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench; a modulo-time display model predicts
// every cycle for an active-high and an active-low instance.
module tb_seg7_scan_driver;
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] den;
  } obs_t;
  logic clk = 1'b0;
  logic i_rst = 1'b1, i_enable = 1'b0, i_load = 1'b0, i_blank_lz = 1'b0;
  logic [15:0] i_value = '0;
  logic [3:0] i_dp = '0;
  logic [6:0] seg_p, seg_n;
  logic dp_p, dp_n;
  logic [3:0] den_p, den_n;
  logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  obs_t exp_q [$];
  int n_vec = 0, n_bad = 0, t = 0;
  bit armed = 0, run = 0;
  logic [15:0] sh_v = '0;
  logic [3:0] sh_dp = '0;
  always #5 clk = ~clk;
  seg7_scan_driver #(.NUM_DIGITS(4), .CLKS_PER_DIGIT(4), .DEAD_CLKS(1),
                     .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_DIG(1'b0)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_load(i_load), .i_value(i_value),
    .i_dp(i_dp), .i_blank_lz(i_blank_lz), .o_segments(seg_p), .o_dp(dp_p), .o_digit_en(den_p));
  seg7_scan_driver #(.NUM_DIGITS(4), .CLKS_PER_DIGIT(4), .DEAD_CLKS(1),
                     .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_DIG(1'b1)) dut_n (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_load(i_load), .i_value(i_value),
    .i_dp(i_dp), .i_blank_lz(i_blank_lz), .o_segments(seg_n), .o_dp(dp_n), .o_digit_en(den_n));
  function automatic void check(string nm, obs_t act, obs_t want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got seg=%h dp=%b en=%b, want seg=%h dp=%b en=%b",
               nm, $time, act.seg, act.dp, act.den, want.seg, want.dp, want.den);
    end
  endfunction
  // Scan position pos counts cycles since enable; a period is 4 digits of 4 lit + 1 dark.
  function automatic obs_t predict(int pos, logic [15:0] v, logic [3:0] d, logic blz);
    obs_t o = '0;
    int ph = pos % 20;
    int dig = ph / 5;
    logic [3:0] nib = v[4*dig +: 4];
    if (ph % 5 < 4) begin
      o.den = 4'(1 << dig);
      o.dp = d[dig];
      o.seg = (blz && dig != 0 && (v >> (4*dig)) == 16'h0) ? 7'h00 : hex7[nib];
    end
    return o;
  endfunction
  task automatic step(input logic r, input logic e, input logic l, input logic [15:0] v,
                      input logic [3:0] d, input logic b);
    obs_t o = '0;
    @(negedge clk);
    i_rst = r; i_enable = e; i_load = l; i_value = v; i_dp = d; i_blank_lz = b;
    if (r) begin
      run = 0; sh_v = '0; sh_dp = '0;
    end else begin
      if (!e) run = 0;
      else if (!run) begin run = 1; t = 0; end
      else t++;
      if (run) o = predict(t, sh_v, sh_dp, b);
      if (l) begin sh_v = v; sh_dp = d; end
    end
    exp_q.push_back(o);
    armed = 1;
  endtask
  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (armed) begin
          n_vec++; n_bad++;
          $display("FAIL scoreboard: no expectation queued @%0t", $time);
        end
      end else begin
        e = exp_q.pop_front();
        check("active_high", {seg_p, dp_p, den_p}, e);
        check("active_low", ~{seg_n, dp_n, den_n}, e);
      end
    end
  end
  initial begin
    logic [15:0] rv;
    repeat (3) step(1, 0, 0, '0, '0, 0);
    step(0, 0, 1, 16'h1234, 4'b0000, 0);
    repeat (45) step(0, 1, 0, '0, '0, 0);
    step(0, 1, 1, 16'h0050, 4'b0100, 1);
    repeat (25) step(0, 1, 0, '0, '0, 1);
    step(0, 1, 1, 16'h0000, 4'b0000, 1);
    repeat (22) step(0, 1, 0, '0, '0, 1);
    step(0, 0, 1, 16'h1234, 4'b0000, 0);
    repeat (6) step(0, 1, 0, '0, '0, 0);
    step(0, 1, 1, 16'h9999, 4'b0000, 0);
    repeat (15) step(0, 1, 0, '0, '0, 0);
    step(0, 0, 0, '0, '0, 0);
    repeat (11) step(0, 1, 0, '0, '0, 0);
    step(0, 0, 0, '0, '0, 0);
    repeat (12) step(0, 1, 0, '0, '0, 0);
    @(posedge clk);
    #3;
    i_rst = 1'b1;
    #1;
    check("async_rst_high", {seg_p, dp_p, den_p}, '0);
    check("async_rst_low", ~{seg_n, dp_n, den_n}, '0);
    repeat (2) step(1, 1, 0, '0, '0, 0);
    repeat (3) step(0, 0, 0, '0, '0, 0);
    repeat (12) step(0, 1, 0, '0, '0, 0);
    repeat (800) begin
      for (int k = 0; k < 4; k++) rv[4*k +: 4] = $urandom_range(0, 1) != 0 ? 4'h0 : 4'($urandom_range(0, 15));
      step(0, $urandom_range(0, 24) != 0, $urandom_range(0, 7) == 0, rv, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Drives an NUM_DIGITS-digit, time-multiplexed, common-segment 7-segment display from one packed hex value.
- Scans one digit at a time, with a programmable dwell and an anti-ghosting dead time between digits.
- Adds per-digit decimal points, optional leading-zero blanking and selectable output polarity.
- Sits between a value source (UART receive path, counters) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
CLKS_PER_DIGIT, 1000, i_clk cycles each digit is lit; must be >= 1.
DEAD_CLKS, 2, i_clk cycles all digits are off between digits; 0 means no dead phase.
ACTIVE_LOW_SEG, 0, when 1, o_segments and o_dp are inverted (0 = lit).
ACTIVE_LOW_DIG, 0, when 1, o_digit_en is inverted (0 = digit selected).

Ports:
i_clk  input  1  system clock; all flops on rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_enable  input  1  scan enable; low blanks the display.
i_load  input  1  one-cycle strobe; captures i_value and i_dp into the shadow registers.
i_value  input  4*NUM_DIGITS  packed nibbles; nibble k is digit k, and digit 0 is the least significant.
i_dp  input  NUM_DIGITS  decimal point per digit.
i_blank_lz  input  1  leading-zero blanking enable.
o_segments  output  7  segment bus [GFEDCBA], registered.
o_dp  output  1  decimal point of the current digit, registered.
o_digit_en  output  NUM_DIGITS  one-hot digit select, registered.

Behaviour:
- Reset (async, i_rst=1):
  - Shadow value and shadow dp are cleared to 0; digit index and dwell counter are cleared to 0; state is IDLE.
  - All outputs show the "off" level: segments and dp unlit, no digit selected. The actual pin levels follow the ACTIVE_LOW_* parameters.
- States:
  - IDLE: outputs off. Moves to ON(digit 0, counter 0) on the first edge where i_enable=1.
  - ON: o_digit_en selects the current digit for exactly CLKS_PER_DIGIT cycles.
    - If DEAD_CLKS>0, then moves to DEAD.
    - If DEAD_CLKS=0, moves directly to ON of the next digit.
  - DEAD: outputs off for exactly DEAD_CLKS cycles, then moves to ON of the next digit.
- Digit index advances and wraps from NUM_DIGITS-1 to 0. Full scan period is NUM_DIGITS*(CLKS_PER_DIGIT+DEAD_CLKS) cycles.
- i_enable=0 in any state: on the next edge, state goes to IDLE with outputs off and index/counter cleared. Re-enabling always restarts at digit 0 with a full dwell.
- All outputs are driven directly from flops, so there are no combinational glitches on the pins. The output flops load on the same edge the state enters a phase.
- Segment encoding, hex 0..F:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:67, A:77, b:7C, C:39, d:5E, E:79, F:71
  - Values are [GFEDCBA], with 1 = lit before polarity is applied.
- Leading-zero blanking (i_blank_lz=1):
  - Digit k is blanked when its nibble and every higher nibble are 0.
  - Digit 0 is never blanked.
  - A blanked digit has its segments unlit but still follows its dp bit, and its o_digit_en is still asserted normally.
- Load:
  - i_load at edge N updates the shadow registers at edge N.
  - While in ON, o_segments and o_dp track the shadow every cycle, so the new digit content appears at edge N+1 without restarting the dwell.
  - i_load and the i_blank_lz evaluation use the shadow, never the live i_value.
- Simultaneous events: i_load together with a phase transition is legal; the newly entered phase uses the new shadow one edge later. i_rst overrides everything.
- Widths:
  - Dwell counter is $clog2(max(CLKS_PER_DIGIT, DEAD_CLKS, 2)) bits.
  - Digit index is $clog2(max(NUM_DIGITS, 2)) bits.
  - No counter may exceed its terminal count.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - the SEG_OFF constant (7'b0000000);
  - the scan state enum (IDLE, ON, DEAD).
- One sub-module, seg7_hex_decode: a combinational nibble-to-[GFEDCBA] lookup built on the package table. It is reusable by other display blocks.
- The scan FSM, blanking logic and polarity inversion live in seg7_scan_driver.

Test Plan:
- All scenarios use NUM_DIGITS=4, CLKS_PER_DIGIT=4, DEAD_CLKS=1 unless stated otherwise.
1. Load 0x1234, enable -> digit0 lit with 66 for 4 cycles, 1 off cycle, digit1 4F, digit2 5B, digit3 06; pattern repeats every 20 cycles.
2. Load 0x0050 with i_blank_lz=1 and i_dp=4'b0100 -> digit3 segments 00, digit2 segments 00 with dp lit, digit1 6D, digit0 3F. Value 0x0000 -> only digit0 shows 3F.
3. ACTIVE_LOW_SEG=1 and ACTIVE_LOW_DIG=1, value 0x8 on digit0 -> o_segments=0000000, o_digit_en=1110; during the dead cycle o_segments=1111111 and o_digit_en=1111.
4. Drop i_enable mid-ON at digit2 -> outputs off on the next edge; re-enable -> digit0 lit for a full 4 cycles.
5. Assert i_rst asynchronously mid-dwell -> outputs off immediately without a clock edge. After release, the display stays off until i_enable is seen, and the shadow reads 0.
6. Pulse i_load with 0x9999 during digit1's 2nd ON cycle -> o_segments changes to 67 one edge later, and digit1 still dwells exactly 4 cycles in total.
